// File: rtl/cs_address_sequencer.sv
// Control-store address sequencer: registered micro-PC plus the n,z,v,c
// condition-code register, selecting increment, conditional jump or decode.
module cs_address_sequencer #(
  parameter int DATAWIDTH_JUMPADDRESS = 11,
  parameter int DATAWIDTH_CONDITION   = 3,
  parameter int DATAWIDTH_FLAGS       = 4
) (
  input  logic                             CS_ADDRESS_SEQUENCER_CLOCK_50,
  input  logic                             CS_ADDRESS_SEQUENCER_ResetInHigh_In,
  input  logic [DATAWIDTH_CONDITION-1:0]   CS_ADDRESS_SEQUENCER_Condition_InBus,
  input  logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_JumpAddress_InBus,
  input  logic [DATAWIDTH_FLAGS-1:0]       CS_ADDRESS_SEQUENCER_ALUFlags_InBus,
  input  logic                             CS_ADDRESS_SEQUENCER_FlagLoad_In,
  input  logic [1:0]                       CS_ADDRESS_SEQUENCER_IROp_InBus,
  input  logic [5:0]                       CS_ADDRESS_SEQUENCER_IROp3_InBus,
  input  logic                             CS_ADDRESS_SEQUENCER_IR13_In,
  input  logic                             CS_ADDRESS_SEQUENCER_Stall_In,
  output logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_CSAddress_OutBus,
  output logic [DATAWIDTH_FLAGS-1:0]       CS_ADDRESS_SEQUENCER_Flags_OutBus,
  output logic                             CS_ADDRESS_SEQUENCER_BranchTaken_Out
);

  typedef enum logic [2:0] {
    SEL_INC    = 3'b000,
    SEL_N      = 3'b001,
    SEL_Z      = 3'b010,
    SEL_V      = 3'b011,
    SEL_C      = 3'b100,
    SEL_IR13   = 3'b101,
    SEL_JUMP   = 3'b110,
    SEL_DECODE = 3'b111
  } sel_e;

  logic [DATAWIDTH_JUMPADDRESS-1:0] addr_q, addr_d;
  logic [DATAWIDTH_FLAGS-1:0]       flags_q, flags_d;
  logic                             br_q, br_d;
  logic                             flag_n, flag_z, flag_v, flag_c;
  sel_e                             sel;

  assign sel = sel_e'(CS_ADDRESS_SEQUENCER_Condition_InBus);
  // Branch conditions always look at the registered flags, never the ALU bus.
  assign {flag_n, flag_z, flag_v, flag_c} = flags_q;

  always_comb begin
    br_d   = 1'b0;
    addr_d = addr_q + 1'b1;
    case (sel)
      SEL_INC:    br_d = 1'b0;
      SEL_N:      br_d = flag_n;
      SEL_Z:      br_d = flag_z;
      SEL_V:      br_d = flag_v;
      SEL_C:      br_d = flag_c;
      SEL_IR13:   br_d = CS_ADDRESS_SEQUENCER_IR13_In;
      SEL_JUMP:   br_d = 1'b1;
      SEL_DECODE: br_d = 1'b1;
      default:    br_d = 1'b0;
    endcase
    if (sel == SEL_DECODE)
      addr_d = {1'b1, CS_ADDRESS_SEQUENCER_IROp_InBus,
                CS_ADDRESS_SEQUENCER_IROp3_InBus, 2'b00};
    else if (br_d)
      addr_d = CS_ADDRESS_SEQUENCER_JumpAddress_InBus;

    flags_d = flags_q;
    if (CS_ADDRESS_SEQUENCER_FlagLoad_In)
      flags_d = CS_ADDRESS_SEQUENCER_ALUFlags_InBus;
  end

  always_ff @(posedge CS_ADDRESS_SEQUENCER_CLOCK_50 or posedge CS_ADDRESS_SEQUENCER_ResetInHigh_In) begin
    if (CS_ADDRESS_SEQUENCER_ResetInHigh_In) begin
      addr_q  <= '0;
      flags_q <= '0;
      br_q    <= 1'b0;
    end else if (!CS_ADDRESS_SEQUENCER_Stall_In) begin
      addr_q  <= addr_d;
      flags_q <= flags_d;
      br_q    <= br_d;
    end
  end

  assign CS_ADDRESS_SEQUENCER_CSAddress_OutBus = addr_q;
  assign CS_ADDRESS_SEQUENCER_Flags_OutBus     = flags_q;
  assign CS_ADDRESS_SEQUENCER_BranchTaken_Out  = br_q;

endmodule
